// File: rtl/ctrl_pkg.sv
// Shared constants for the multicycle RV32I main control FSM:
// state encodings, opcodes, ALUOp codes and datapath select codes.
// Optional feature macro used by the users of this package: ILLEGAL_TRAP_EN.
package ctrl_pkg;

  // State encodings (4-bit; the state register may be wider)
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_EXECUTEI = 4'd8;
  localparam logic [3:0] S_JAL      = 4'd9;
  localparam logic [3:0] S_BEQ      = 4'd10;
  localparam logic [3:0] S_ILLEGAL  = 4'd11;

  // Opcodes, instr[6:0]
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // ALUOp handed to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU operand A select
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Result bus select
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/ctrl_out_dec.sv
// Purely combinational control-output decoder for the multicycle control
// FSM. Outputs depend on the state only, except that the FETCH enables
// follow mem_ready_i. Unlisted outputs are 0, and unused state encodings
// decode to all-zero (no enables).
// Optional feature macro: ILLEGAL_TRAP_EN (adds illegal_instr_o).
module ctrl_out_dec
  import ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic [STATE_W-1:0] state_i,
  input  logic               mem_ready_i,
  output logic [1:0]         aluop_o,
  output logic [1:0]         alusrca_o,
  output logic [1:0]         alusrcb_o,
  output logic [1:0]         resultsrc_o,
  output logic               adrsrc_o,
  output logic               irwrite_o,
  output logic               pcupdate_o,
  output logic               branch_o,
  output logic               regwrite_o,
  output logic               memwrite_o
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic               illegal_instr_o
`endif
);

  // Decode every control output from the current state
  always_comb begin
    aluop_o     = ALUOP_ADD;
    alusrca_o   = SRCA_PC;
    alusrcb_o   = SRCB_RS2;
    resultsrc_o = RES_ALUOUT;
    adrsrc_o    = 1'b0;
    irwrite_o   = 1'b0;
    pcupdate_o  = 1'b0;
    branch_o    = 1'b0;
    regwrite_o  = 1'b0;
    memwrite_o  = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    illegal_instr_o = 1'b0;
`endif
    case (state_i)
      STATE_W'(S_FETCH): begin
        // PC + 4 through the ALU; the IR only loads once memory answers
        alusrca_o   = SRCA_PC;
        alusrcb_o   = SRCB_FOUR;
        aluop_o     = ALUOP_ADD;
        resultsrc_o = RES_ALU;
        irwrite_o   = mem_ready_i;
        pcupdate_o  = mem_ready_i;
      end
      STATE_W'(S_DECODE): begin
        // Branch/jump target OldPC + imm, computed speculatively
        alusrca_o = SRCA_OLDPC;
        alusrcb_o = SRCB_IMM;
        aluop_o   = ALUOP_ADD;
      end
      STATE_W'(S_MEMADR): begin
        alusrca_o = SRCA_RS1;
        alusrcb_o = SRCB_IMM;
        aluop_o   = ALUOP_ADD;
      end
      STATE_W'(S_MEMREAD): begin
        adrsrc_o    = 1'b1;
        resultsrc_o = RES_ALUOUT;
      end
      STATE_W'(S_MEMWB): begin
        resultsrc_o = RES_RDATA;
        regwrite_o  = 1'b1;
      end
      STATE_W'(S_MEMWRITE): begin
        // Write enable is held for the whole stall so memory sees a stable request
        adrsrc_o    = 1'b1;
        resultsrc_o = RES_ALUOUT;
        memwrite_o  = 1'b1;
      end
      STATE_W'(S_EXECUTER): begin
        alusrca_o = SRCA_RS1;
        alusrcb_o = SRCB_RS2;
        aluop_o   = ALUOP_FUNCT;
      end
      STATE_W'(S_EXECUTEI): begin
        alusrca_o = SRCA_RS1;
        alusrcb_o = SRCB_IMM;
        aluop_o   = ALUOP_FUNCT;
      end
      STATE_W'(S_ALUWB): begin
        resultsrc_o = RES_ALUOUT;
        regwrite_o  = 1'b1;
      end
      STATE_W'(S_BEQ): begin
        // Subtract compares rs1/rs2; target from DECODE sits in ALUOut
        alusrca_o   = SRCA_RS1;
        alusrcb_o   = SRCB_RS2;
        aluop_o     = ALUOP_SUB;
        resultsrc_o = RES_ALUOUT;
        branch_o    = 1'b1;
      end
      STATE_W'(S_JAL): begin
        // Jump to the target in ALUOut while computing the link OldPC + 4
        alusrca_o   = SRCA_OLDPC;
        alusrcb_o   = SRCB_FOUR;
        aluop_o     = ALUOP_ADD;
        resultsrc_o = RES_ALUOUT;
        pcupdate_o  = 1'b1;
      end
`ifdef ILLEGAL_TRAP_EN
      STATE_W'(S_ILLEGAL): begin
        illegal_instr_o = 1'b1;
      end
`endif
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multicycle RV32I core. Holds the state register
// and next-state logic; control outputs come from ctrl_out_dec.
// Memory stalls use a single-bit ready: FETCH, MEMREAD and MEMWRITE wait
// for mem_ready=1. Reset is asynchronous, active-high, and forces FETCH.
// Optional feature macro: ILLEGAL_TRAP_EN -- unrecognised opcodes trap in
// ILLEGAL (flagged on illegal_instr) instead of retiring as a NOP.
module multicycle_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  input  logic               mem_ready,
  output logic [1:0]         ALUOp,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ResultSrc,
  output logic               AdrSrc,
  output logic               IRWrite,
  output logic               PCUpdate,
  output logic               Branch,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic [STATE_W-1:0] state_dbg
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic               illegal_instr
`endif
);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic               mem_ready_gated;

  // State register, async-cleared to FETCH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= STATE_W'(S_FETCH);
    else       state_q <= state_d;
  end

  // Next-state sequencing through fetch/decode/execute/memory/writeback
  always_comb begin
    state_d = state_q;
    case (state_q)
      STATE_W'(S_FETCH):    if (mem_ready) state_d = STATE_W'(S_DECODE);
      STATE_W'(S_DECODE): begin
        case (op)
          OP_LOAD, OP_STORE: state_d = STATE_W'(S_MEMADR);
          OP_RTYPE:          state_d = STATE_W'(S_EXECUTER);
          OP_ITYPE:          state_d = STATE_W'(S_EXECUTEI);
          OP_BRANCH:         state_d = STATE_W'(S_BEQ);
          OP_JAL:            state_d = STATE_W'(S_JAL);
`ifdef ILLEGAL_TRAP_EN
          default:           state_d = STATE_W'(S_ILLEGAL);
`else
          // PC already advanced in FETCH, so dropping back retires a NOP
          default:           state_d = STATE_W'(S_FETCH);
`endif
        endcase
      end
      // op[5] separates store (0100011) from load (0000011)
      STATE_W'(S_MEMADR):   state_d = op[5] ? STATE_W'(S_MEMWRITE) : STATE_W'(S_MEMREAD);
      STATE_W'(S_MEMREAD):  if (mem_ready) state_d = STATE_W'(S_MEMWB);
      STATE_W'(S_MEMWB):    state_d = STATE_W'(S_FETCH);
      STATE_W'(S_MEMWRITE): if (mem_ready) state_d = STATE_W'(S_FETCH);
      STATE_W'(S_EXECUTER): state_d = STATE_W'(S_ALUWB);
      STATE_W'(S_EXECUTEI): state_d = STATE_W'(S_ALUWB);
      STATE_W'(S_ALUWB):    state_d = STATE_W'(S_FETCH);
      STATE_W'(S_BEQ):      state_d = STATE_W'(S_FETCH);
      STATE_W'(S_JAL):      state_d = STATE_W'(S_ALUWB);
`ifdef ILLEGAL_TRAP_EN
      // Trap is sticky; only reset leaves it
      STATE_W'(S_ILLEGAL):  state_d = STATE_W'(S_ILLEGAL);
`endif
      default:              state_d = STATE_W'(S_FETCH);
    endcase
  end

  // While reset is high the FETCH enables must stay low
  assign mem_ready_gated = mem_ready & ~reset;
  assign state_dbg       = state_q;

  ctrl_out_dec #(
    .STATE_W (STATE_W)
  ) u_out_dec (
    .state_i     (state_q),
    .mem_ready_i (mem_ready_gated),
    .aluop_o     (ALUOp),
    .alusrca_o   (ALUSrcA),
    .alusrcb_o   (ALUSrcB),
    .resultsrc_o (ResultSrc),
    .adrsrc_o    (AdrSrc),
    .irwrite_o   (IRWrite),
    .pcupdate_o  (PCUpdate),
    .branch_o    (Branch),
    .regwrite_o  (RegWrite),
    .memwrite_o  (MemWrite)
`ifdef ILLEGAL_TRAP_EN
    ,
    .illegal_instr_o (illegal_instr)
`endif
  );

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm. Instructions are expanded into per-cycle
// (state, mem_ready) steps from the instruction class; each cycle's
// expected output vector is queued by the driver and checked by a
// separate negedge monitor. Honours ILLEGAL_TRAP_EN.
module tb_multicycle_ctrl_fsm;

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BEQ = 4, K_JAL = 5, K_BAD = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [6:0] op;
  logic       mem_ready;
  logic [1:0] ALUOp, ALUSrcA, ALUSrcB, ResultSrc;
  logic       AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite;
  logic [3:0] state_dbg;
  logic       illegal_w;

  multicycle_ctrl_fsm dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .mem_ready (mem_ready),
    .ALUOp     (ALUOp),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ResultSrc (ResultSrc),
    .AdrSrc    (AdrSrc),
    .IRWrite   (IRWrite),
    .PCUpdate  (PCUpdate),
    .Branch    (Branch),
    .RegWrite  (RegWrite),
    .MemWrite  (MemWrite),
    .state_dbg (state_dbg)
`ifdef ILLEGAL_TRAP_EN
    ,
    .illegal_instr (illegal_w)
`endif
  );

`ifndef ILLEGAL_TRAP_EN
  assign illegal_w = 1'b0;
`endif

  // ---------------- reference model ----------------
  // Vector: {illegal, state[3:0], ALUOp, SrcA, SrcB, Result, AdrSrc,
  //          IRWrite, PCUpdate, Branch, RegWrite, MemWrite}
  logic [18:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [18:0] model(int st, bit mr, bit rst);
    logic [1:0] aop, sa, sb, rs;
    logic adr, irw, pcu, br, rw, mw, ill;
    int s;
    aop = 2'b00; sa = 2'b00; sb = 2'b00; rs = 2'b00;
    adr = 0; irw = 0; pcu = 0; br = 0; rw = 0; mw = 0; ill = 0;
    s = rst ? 0 : st;
    case (s)
      0:  begin sb = 2'b10; rs = 2'b10; irw = mr & ~rst; pcu = mr & ~rst; end
      1:  begin sa = 2'b01; sb = 2'b01; end
      2:  begin sa = 2'b10; sb = 2'b01; end
      3:  begin adr = 1; end
      4:  begin rs = 2'b01; rw = 1; end
      5:  begin adr = 1; mw = 1; end
      6:  begin sa = 2'b10; sb = 2'b00; aop = 2'b10; end
      7:  begin rw = 1; end
      8:  begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
      9:  begin sa = 2'b01; sb = 2'b10; pcu = 1; end
      10: begin sa = 2'b10; aop = 2'b01; br = 1; end
      11: begin ill = 1; end
      default: begin end
    endcase
    return {ill, 4'(s), aop, sa, sb, rs, adr, irw, pcu, br, rw, mw};
  endfunction

  function automatic bit is_known(logic [6:0] o);
    return (o == 7'b0000011) || (o == 7'b0100011) || (o == 7'b0110011) ||
           (o == 7'b0010011) || (o == 7'b1100011) || (o == 7'b1101111);
  endfunction

  // ---------------- driver tasks ----------------
  // One cycle: drive inputs just after the edge, queue the expectation
  task automatic cyc(input bit r, input logic [6:0] o, input bit mr, input int st);
    @(posedge clk);
    #1;
    reset     = r;
    op        = o;
    mem_ready = mr;
    exp_q.push_back(model(st, mr, r));
  endtask

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expand one instruction into its per-cycle step sequence
  task automatic run_instr(input int kind, input int fstall, input int mstall, input logic [6:0] bad_op);
    logic [6:0] o;
    case (kind)
      K_LW:    o = 7'b0000011;
      K_SW:    o = 7'b0100011;
      K_R:     o = 7'b0110011;
      K_I:     o = 7'b0010011;
      K_BEQ:   o = 7'b1100011;
      K_JAL:   o = 7'b1101111;
      default: o = bad_op;
    endcase
    for (int i = 0; i < fstall; i++) cyc(0, o, 0, 0);
    cyc(0, o, 1, 0);
    cyc(0, o, rb(), 1);
    case (kind)
      K_LW: begin
        cyc(0, o, rb(), 2);
        for (int i = 0; i < mstall; i++) cyc(0, o, 0, 3);
        cyc(0, o, 1, 3);
        cyc(0, o, rb(), 4);
      end
      K_SW: begin
        cyc(0, o, rb(), 2);
        for (int i = 0; i < mstall; i++) cyc(0, o, 0, 5);
        cyc(0, o, 1, 5);
      end
      K_R:   begin cyc(0, o, rb(), 6); cyc(0, o, rb(), 7); end
      K_I:   begin cyc(0, o, rb(), 8); cyc(0, o, rb(), 7); end
      K_BEQ: begin cyc(0, o, rb(), 10); end
      K_JAL: begin cyc(0, o, rb(), 9); cyc(0, o, rb(), 7); end
      default: begin
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 10; i++) cyc(0, o, rb(), 11);
        cyc(1, o, rb(), 0);
`endif
      end
    endcase
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [18:0] exp_v, act_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {illegal_w, state_dbg, ALUOp, ALUSrcA, ALUSrcB, ResultSrc,
               AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL ctrl_vec t=%0t actual=%b expected=%b (ill,state,aluop,srca,srcb,res,adr,ir,pcu,br,rw,mw)",
                 $time, act_v, exp_v);
      end
      n_cmp++;
      if ((RegWrite & MemWrite) !== 1'b0) begin
        n_bad++;
        $display("FAIL write_excl t=%0t actual RegWrite=%b MemWrite=%b required not both high",
                 $time, RegWrite, MemWrite);
      end
    end
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [6:0] bad;
    int kind;
    reset     = 1'b1;
    op        = 7'd0;
    mem_ready = 1'b0;
    cyc(1, 7'd0, 0, 0);
    cyc(1, 7'd0, 1, 0);

    // Reset hit mid-EXECUTER, then a full R-type from FETCH
    cyc(0, 7'b0110011, 1, 0);
    cyc(0, 7'b0110011, 1, 1);
    cyc(1, 7'b0110011, 1, 6);
    cyc(1, 7'b0110011, 1, 0);
    run_instr(K_R, 0, 0, 7'd0);

    // Directed: lw no stalls, sw 3 stalls, R/I/beq/jal, FETCH 2 stalls, bad op
    run_instr(K_LW, 0, 0, 7'd0);
    run_instr(K_SW, 0, 3, 7'd0);
    run_instr(K_R, 0, 0, 7'd0);
    run_instr(K_I, 0, 0, 7'd0);
    run_instr(K_BEQ, 0, 0, 7'd0);
    run_instr(K_JAL, 0, 0, 7'd0);
    run_instr(K_I, 2, 0, 7'd0);
    run_instr(K_BAD, 0, 0, 7'b1111111);
    run_instr(K_LW, 1, 2, 7'd0);

    // Random instruction mix with random stalls
    for (int n = 0; n < 250; n++) begin
      kind = $urandom_range(0, 6);
      do bad = 7'($urandom_range(0, 127)); while (is_known(bad));
      run_instr(kind, $urandom_range(0, 3), $urandom_range(0, 3), bad);
      if ($urandom_range(0, 19) == 0) cyc(1, 7'd0, rb(), 0);
    end

    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain actual=%0d left required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
